lsu_split_access: RTL and testbench

//  Parametrised memory-stage load/store unit with a registered memory handshake.

---
 rtl/lsu_pkg.sv | 55 +++++
 rtl/lsu_split_access_align.sv | 70 +++++++
 rtl/lsu_split_access.sv | 180 ++++++++++++++++++
 tb/tb_lsu_split_access.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the split-access load/store unit: funct3 encodings,
// FSM state type and access-size helpers.
package lsu_pkg;

  // Load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Store encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // Access size in bytes from the low two funct3 bits (1, 2, 4 or 8)
  function automatic logic [3:0] size_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 4'd1;
      2'd1:    return 4'd2;
      2'd2:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  // Whether funct3 names a real access for this direction and word width
  function automatic logic f3_legal(input logic store, input logic [2:0] f3,
                                    input logic wide);
    if (store) begin
      case (f3)
        F3_SB, F3_SH, F3_SW: return 1'b1;
        F3_SD:               return wide;
        default:             return 1'b0;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: return 1'b1;
        F3_LD, F3_LWU:                       return wide;
        default:                             return 1'b0;
      endcase
    end
  endfunction

endpackage

// File: rtl/lsu_split_access_align.sv
// Byte-lane steering for the LSU: store rotate/mask generation for both beats,
// and load merge/rotate/extend from the two captured read words.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] off,
  input  logic [2:0]                funct3,
  input  logic [XLEN-1:0]           wdata,
  output logic [XLEN/8-1:0]         mask0,
  output logic [XLEN/8-1:0]         mask1,
  output logic [XLEN-1:0]           wdata0,
  output logic [XLEN-1:0]           wdata1,
  input  logic [XLEN-1:0]           rdata0,
  input  logic [XLEN-1:0]           rdata1,
  output logic [XLEN-1:0]           load_data
);

  localparam int BYTES = XLEN/8;

  logic [3:0]         size;
  logic [2*BYTES-1:0] span;
  logic [2*BYTES-1:0] span_sh;
  logic [2*XLEN-1:0]  rot_w;
  logic [XLEN-1:0]    rot;
  logic [2*XLEN-1:0]  merged;

  // Expand a byte mask into a bit mask
  function automatic logic [XLEN-1:0] lanes(input logic [BYTES-1:0] m);
    logic [XLEN-1:0] r;
    r = '0;
    for (int i = 0; i < BYTES; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

  // Truncate to the access size, then sign- or zero-extend (funct3[2] = unsigned)
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d,
                                             input logic [2:0] f3);
    logic [XLEN-1:0] r;
    logic            sgn;
    logic [3:0]      sz;
    sz = size_bytes(f3);
    case (f3[1:0])
      2'd0:    sgn = d[7];
      2'd1:    sgn = d[15];
      default: sgn = d[31];
    endcase
    sgn = sgn & ~f3[2];
    for (int i = 0; i < XLEN; i++) r[i] = (i < 8*int'(sz)) ? d[i] : sgn;
    return r;
  endfunction

  // Lane masks, rotated store data and merged load data
  always_comb begin
    size = size_bytes(funct3);
    for (int i = 0; i < 2*BYTES; i++) span[i] = (i < int'(size));
    // Two-word span: the low half is beat0's lanes, the high half beat1's
    span_sh = span << off;
    mask0   = span_sh[BYTES-1:0];
    mask1   = span_sh[2*BYTES-1:BYTES];
    rot_w   = {wdata, wdata} << {off, 3'b000};
    rot     = rot_w[2*XLEN-1:XLEN];
    wdata0  = rot & lanes(mask0);
    wdata1  = rot & lanes(mask1);
    merged  = {rdata1, rdata0} >> {off, 3'b000};
    load_data = extend(merged[XLEN-1:0], funct3);
  end

endmodule

// File: rtl/lsu_split_access.sv
// Memory-stage load/store unit. Accepts one access at a time, issues one or two
// aligned beats to a variable-latency single-port memory, and returns a
// one-cycle response with extended load data or fault flags.
module lsu_split_access
  import lsu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_misalign,
  output logic              rsp_illegal,
  output logic              mem_cs_n,
  output logic              mem_we_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN/8-1:0] mem_wmask,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_valid
);

  localparam int BYTES = XLEN/8;
  localparam int OFF_W = $clog2(BYTES);

  lsu_state_e state, nxt;

  // Captured request and first read beat
  logic [ADDR_W-1:0] addr_p0;
  logic [2:0]        f3_p0;
  logic              store_p0;
  logic [XLEN-1:0]   wdata_p0;
  logic [XLEN-1:0]   rdata0_p0;

  // Request view: live inputs while idle, captured copy while busy
  logic [ADDR_W-1:0] a_cur;
  logic [2:0]        f3_cur;
  logic              store_cur;
  logic [XLEN-1:0]   wd_cur;
  logic [OFF_W-1:0]  off_cur;
  logic [ADDR_W-1:0] word_cur;
  logic [3:0]        size_cur;
  logic              cross_cur;
  logic              legal_cur;

  logic [BYTES-1:0]  mask0, mask1;
  logic [XLEN-1:0]   wdata0, wdata1;
  logic [XLEN-1:0]   beat0_rd;
  logic [XLEN-1:0]   load_data;

  // Decode the access currently being worked on
  always_comb begin
    if (state == ST_IDLE) begin
      a_cur     = addr;
      f3_cur    = funct3;
      store_cur = req_store;
      wd_cur    = wdata;
    end else begin
      a_cur     = addr_p0;
      f3_cur    = f3_p0;
      store_cur = store_p0;
      wd_cur    = wdata_p0;
    end
    off_cur   = a_cur[OFF_W-1:0];
    word_cur  = {a_cur[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    size_cur  = size_bytes(f3_cur);
    cross_cur = (int'(off_cur) + int'(size_cur)) > BYTES;
    legal_cur = f3_legal(store_cur, f3_cur, XLEN == 64);
    // The first beat is still on the bus while in BEAT0
    beat0_rd  = (state == ST_BEAT0) ? mem_rdata : rdata0_p0;
  end

  lsu_align #(.XLEN(XLEN)) u_align (
    .off       (off_cur),
    .funct3    (f3_cur),
    .wdata     (wd_cur),
    .mask0     (mask0),
    .mask1     (mask1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .rdata0    (beat0_rd),
    .rdata1    (mem_rdata),
    .load_data (load_data)
  );

  // Next-state logic and pipeline handshake
  always_comb begin
    nxt       = state;
    req_ready = (state == ST_IDLE);
    stall     = ((state == ST_IDLE) & req_valid) | (state == ST_BEAT0) |
                (state == ST_BEAT1);
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (!legal_cur || (cross_cur && !MISALIGN_EN)) nxt = ST_RESP;
          else                                           nxt = ST_BEAT0;
        end
      end
      ST_BEAT0: if (mem_valid) nxt = cross_cur ? ST_BEAT1 : ST_RESP;
      ST_BEAT1: if (mem_valid) nxt = ST_RESP;
      default:  nxt = ST_IDLE;
    endcase
  end

  // State register; reset abandons any in-flight beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  // Request and first-beat capture (data only, no reset needed)
  always_ff @(posedge clk) begin
    if ((state == ST_IDLE) && req_valid) begin
      addr_p0  <= addr;
      f3_p0    <= funct3;
      store_p0 <= req_store;
      wdata_p0 <= wdata;
    end
    if ((state == ST_BEAT0) && mem_valid) rdata0_p0 <= mem_rdata;
  end

  // Registered memory interface, held stable for the whole beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_cs_n  <= 1'b1;
      mem_we_n  <= 1'b1;
      mem_addr  <= '0;
      mem_wmask <= '0;
      mem_wdata <= '0;
    end else if ((state == ST_IDLE) && (nxt == ST_BEAT0)) begin
      mem_cs_n  <= 1'b0;
      mem_we_n  <= ~req_store;
      mem_addr  <= word_cur;
      mem_wmask <= mask0;
      mem_wdata <= wdata0;
    end else if ((state == ST_BEAT0) && (nxt == ST_BEAT1)) begin
      // Next word; wraps naturally at the top of the address space
      mem_addr  <= word_cur + ADDR_W'(BYTES);
      mem_wmask <= mask1;
      mem_wdata <= wdata1;
    end else if ((state != ST_IDLE) && (nxt == ST_RESP)) begin
      mem_cs_n  <= 1'b1;
      mem_we_n  <= 1'b1;
      mem_addr  <= '0;
      mem_wmask <= '0;
      mem_wdata <= '0;
    end
  end

  // Response registers, live for exactly the RESP cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_misalign <= 1'b0;
      rsp_illegal  <= 1'b0;
    end else if (nxt == ST_RESP) begin
      rsp_valid    <= 1'b1;
      rsp_illegal  <= (state == ST_IDLE) & ~legal_cur;
      rsp_misalign <= (state == ST_IDLE) & legal_cur & cross_cur & !MISALIGN_EN;
      rsp_rdata    <= ((state != ST_IDLE) && !store_cur) ? load_data : '0;
    end else begin
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_misalign <= 1'b0;
      rsp_illegal  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lsu_split_access.sv
// Directed bench for lsu_split_access: 32-bit split-enabled, 32-bit trapping
// and 64-bit instances share stimulus; sel picks which one is driven/observed.
module tb_lsu_split_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic [63:0] mem_rdata;
  logic        mem_valid;
  logic        rv_a, rv_b, rv_c;
  int          sel;

  logic        ready_a, stall_a, rv_out_a, mis_a, ill_a, cs_a, we_a;
  logic [31:0] rdata_a, maddr_a, mwd_a;
  logic [3:0]  mask_a;
  logic        ready_b, stall_b, rv_out_b, mis_b, ill_b, cs_b, we_b;
  logic [31:0] rdata_b, maddr_b, mwd_b;
  logic [3:0]  mask_b;
  logic        ready_c, stall_c, rv_out_c, mis_c, ill_c, cs_c, we_c;
  logic [63:0] rdata_c, mwd_c;
  logic [31:0] maddr_c;
  logic [7:0]  mask_c;

  logic        o_ready, o_stall, o_rv, o_mis, o_ill, o_cs_n, o_we_n;
  logic [63:0] o_rdata, o_wdata;
  logic [31:0] o_addr;
  logic [7:0]  o_mask;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_split_access #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .req_valid(rv_a), .req_ready(ready_a),
    .req_store(req_store), .funct3(funct3), .addr(addr), .wdata(wdata[31:0]),
    .stall(stall_a), .rsp_valid(rv_out_a), .rsp_rdata(rdata_a),
    .rsp_misalign(mis_a), .rsp_illegal(ill_a), .mem_cs_n(cs_a), .mem_we_n(we_a),
    .mem_addr(maddr_a), .mem_wmask(mask_a), .mem_wdata(mwd_a),
    .mem_rdata(mem_rdata[31:0]), .mem_valid(mem_valid));

  lsu_split_access #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(rv_b), .req_ready(ready_b),
    .req_store(req_store), .funct3(funct3), .addr(addr), .wdata(wdata[31:0]),
    .stall(stall_b), .rsp_valid(rv_out_b), .rsp_rdata(rdata_b),
    .rsp_misalign(mis_b), .rsp_illegal(ill_b), .mem_cs_n(cs_b), .mem_we_n(we_b),
    .mem_addr(maddr_b), .mem_wmask(mask_b), .mem_wdata(mwd_b),
    .mem_rdata(mem_rdata[31:0]), .mem_valid(mem_valid));

  lsu_split_access #(.XLEN(64), .ADDR_W(32), .MISALIGN_EN(1'b1)) dut_c (
    .clk(clk), .rst(rst), .req_valid(rv_c), .req_ready(ready_c),
    .req_store(req_store), .funct3(funct3), .addr(addr), .wdata(wdata),
    .stall(stall_c), .rsp_valid(rv_out_c), .rsp_rdata(rdata_c),
    .rsp_misalign(mis_c), .rsp_illegal(ill_c), .mem_cs_n(cs_c), .mem_we_n(we_c),
    .mem_addr(maddr_c), .mem_wmask(mask_c), .mem_wdata(mwd_c),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid));

  always_comb begin
    case (sel)
      1: begin
        o_ready = ready_b; o_stall = stall_b; o_rv = rv_out_b; o_mis = mis_b;
        o_ill = ill_b; o_cs_n = cs_b; o_we_n = we_b; o_rdata = {32'h0, rdata_b};
        o_wdata = {32'h0, mwd_b}; o_addr = maddr_b; o_mask = {4'h0, mask_b};
      end
      2: begin
        o_ready = ready_c; o_stall = stall_c; o_rv = rv_out_c; o_mis = mis_c;
        o_ill = ill_c; o_cs_n = cs_c; o_we_n = we_c; o_rdata = rdata_c;
        o_wdata = mwd_c; o_addr = maddr_c; o_mask = mask_c;
      end
      default: begin
        o_ready = ready_a; o_stall = stall_a; o_rv = rv_out_a; o_mis = mis_a;
        o_ill = ill_a; o_cs_n = cs_a; o_we_n = we_a; o_rdata = {32'h0, rdata_a};
        o_wdata = {32'h0, mwd_a}; o_addr = maddr_a; o_mask = {4'h0, mask_a};
      end
    endcase
  end

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_rv(input logic v);
    rv_a = v && (sel == 0);
    rv_b = v && (sel == 1);
    rv_c = v && (sel == 2);
  endtask

  // Present one request for one cycle; returns at the next falling edge
  task automatic issue(input string tag, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [63:0] wd);
    req_store = st; funct3 = f3; addr = a; wdata = wd;
    set_rv(1'b1);
    #1;
    check_eq({tag, "_issue_stall"}, o_stall, 1);
    check_eq({tag, "_issue_ready"}, o_ready, 1);
    @(negedge clk);
    set_rv(1'b0);
  endtask

  // Observe one beat for waits+1 cycles, completing it in the last
  task automatic beat(input string tag, input logic we_n, input logic [31:0] a,
                      input logic [7:0] m, input logic [63:0] wd,
                      input logic [63:0] rd, input int waits);
    for (int w = 0; w <= waits; w++) begin
      #1;
      check_eq({tag, "_cs_n"},  o_cs_n, 0);
      check_eq({tag, "_we_n"},  o_we_n, we_n);
      check_eq({tag, "_addr"},  o_addr, a);
      check_eq({tag, "_mask"},  o_mask, m);
      check_eq({tag, "_wdata"}, o_wdata, wd);
      check_eq({tag, "_stall"}, o_stall, 1);
      check_eq({tag, "_rvld"},  o_rv, 0);
      if (w == waits) begin
        mem_valid = 1'b1;
        mem_rdata = rd;
      end
      @(negedge clk);
      mem_valid = 1'b0;
    end
  endtask

  // Observe the response cycle and the return to idle
  task automatic resp(input string tag, input logic [63:0] rd, input logic mis,
                      input logic ill);
    #1;
    check_eq({tag, "_rsp_valid"}, o_rv, 1);
    check_eq({tag, "_rsp_rdata"}, o_rdata, rd);
    check_eq({tag, "_rsp_mis"},   o_mis, mis);
    check_eq({tag, "_rsp_ill"},   o_ill, ill);
    check_eq({tag, "_rsp_stall"}, o_stall, 0);
    check_eq({tag, "_rsp_cs_n"},  o_cs_n, 1);
    @(negedge clk);
    #1;
    check_eq({tag, "_post_valid"}, o_rv, 0);
    check_eq({tag, "_post_ready"}, o_ready, 1);
    @(negedge clk);
  endtask

  initial begin
    sel = 0; rst = 1'b1; req_store = 1'b0; funct3 = 3'b0; addr = 32'h0;
    wdata = 64'h0; mem_rdata = 64'h0; mem_valid = 1'b0;
    set_rv(1'b0);
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_ready", o_ready, 1);
    check_eq("rst_stall", o_stall, 0);
    check_eq("rst_rvld",  o_rv, 0);
    check_eq("rst_rdata", o_rdata, 0);
    check_eq("rst_cs_n",  o_cs_n, 1);
    check_eq("rst_we_n",  o_we_n, 1);
    check_eq("rst_addr",  o_addr, 0);
    check_eq("rst_mask",  o_mask, 0);
    check_eq("rst_wdata", o_wdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // Aligned word load, zero wait
    issue("lw", 1'b0, 3'b010, 32'h100, 64'h0);
    beat("lw_b0", 1'b1, 32'h100, 8'h0F, 64'h0, 64'hDEADBEEF, 0);
    resp("lw", 64'hDEADBEEF, 1'b0, 1'b0);

    // Signed byte load with three wait states, then unsigned
    issue("lb", 1'b0, 3'b000, 32'h103, 64'h0);
    beat("lb_b0", 1'b1, 32'h100, 8'h08, 64'h0, 64'h80FF0000, 3);
    resp("lb", 64'hFFFFFF80, 1'b0, 1'b0);
    issue("lbu", 1'b0, 3'b100, 32'h103, 64'h0);
    beat("lbu_b0", 1'b1, 32'h100, 8'h08, 64'h0, 64'h80FF0000, 0);
    resp("lbu", 64'h00000080, 1'b0, 1'b0);

    // Halfword store in the upper lanes
    issue("sh", 1'b1, 3'b001, 32'h102, 64'h0000ABCD);
    beat("sh_b0", 1'b0, 32'h100, 8'h0C, 64'hABCD0000, 64'h0, 0);
    resp("sh", 64'h0, 1'b0, 1'b0);

    // Word store crossing into the next word
    issue("sw", 1'b1, 3'b010, 32'h103, 64'h11223344);
    beat("sw_b0", 1'b0, 32'h100, 8'h08, 64'h44000000, 64'h0, 0);
    beat("sw_b1", 1'b0, 32'h104, 8'h07, 64'h00112233, 64'h0, 0);
    resp("sw", 64'h0, 1'b0, 1'b0);

    // Split word load with a wait on the second beat
    issue("lws", 1'b0, 3'b010, 32'h102, 64'h0);
    beat("lws_b0", 1'b1, 32'h100, 8'h0C, 64'h0, 64'h33445566, 0);
    beat("lws_b1", 1'b1, 32'h104, 8'h03, 64'h0, 64'h77881122, 1);
    resp("lws", 64'h11223344, 1'b0, 1'b0);

    // Split signed halfword load
    issue("lhs", 1'b0, 3'b001, 32'h103, 64'h0);
    beat("lhs_b0", 1'b1, 32'h100, 8'h08, 64'h0, 64'h12000000, 0);
    beat("lhs_b1", 1'b1, 32'h104, 8'h01, 64'h0, 64'h000000F0, 0);
    resp("lhs", 64'hFFFFF012, 1'b0, 1'b0);

    // Illegal encodings on the 32-bit unit
    issue("ld32", 1'b0, 3'b011, 32'h100, 64'h0);
    resp("ld32", 64'h0, 1'b0, 1'b1);
    issue("sill", 1'b1, 3'b100, 32'h100, 64'h55);
    resp("sill", 64'h0, 1'b0, 1'b1);

    // mem_valid while idle must not start anything
    mem_valid = 1'b1;
    @(negedge clk);
    mem_valid = 1'b0;
    #1;
    check_eq("idle_mv_rvld",  o_rv, 0);
    check_eq("idle_mv_cs_n",  o_cs_n, 1);
    check_eq("idle_mv_ready", o_ready, 1);
    @(negedge clk);

    // Trapping instance: crossing load faults, aligned load works
    sel = 1;
    issue("mis", 1'b0, 3'b010, 32'h102, 64'h0);
    resp("mis", 64'h0, 1'b1, 1'b0);
    issue("nm_lw", 1'b0, 3'b010, 32'h104, 64'h0);
    beat("nm_lw_b0", 1'b1, 32'h104, 8'h0F, 64'h0, 64'hCAFEF00D, 0);
    resp("nm_lw", 64'hCAFEF00D, 1'b0, 1'b0);

    // Reset during BEAT1 with the beat still pending
    sel = 0;
    issue("rsw", 1'b1, 3'b010, 32'h103, 64'h11223344);
    beat("rsw_b0", 1'b0, 32'h100, 8'h08, 64'h44000000, 64'h0, 0);
    #1;
    check_eq("rsw_b1_cs_n", o_cs_n, 0);
    check_eq("rsw_b1_addr", o_addr, 32'h104);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_cs_n",  o_cs_n, 1);
    check_eq("mid_rst_we_n",  o_we_n, 1);
    check_eq("mid_rst_addr",  o_addr, 0);
    check_eq("mid_rst_mask",  o_mask, 0);
    check_eq("mid_rst_wdata", o_wdata, 0);
    check_eq("mid_rst_ready", o_ready, 1);
    check_eq("mid_rst_stall", o_stall, 0);
    check_eq("mid_rst_rvld",  o_rv, 0);
    rst = 1'b0;
    @(negedge clk);
    issue("lw2", 1'b0, 3'b010, 32'h100, 64'h0);
    beat("lw2_b0", 1'b1, 32'h100, 8'h0F, 64'h0, 64'h0BADF00D, 0);
    resp("lw2", 64'h0BADF00D, 1'b0, 1'b0);

    // 64-bit unit: doubleword load wrapping past the top of memory
    sel = 2;
    issue("ld64", 1'b0, 3'b011, 32'hFFFFFFFC, 64'h0);
    beat("ld64_b0", 1'b1, 32'hFFFFFFF8, 8'hF0, 64'h0, 64'h8877665544332211, 0);
    beat("ld64_b1", 1'b1, 32'h00000000, 8'h0F, 64'h0, 64'h00000000DDCCBBAA, 0);
    resp("ld64", 64'hDDCCBBAA88776655, 1'b0, 1'b0);

    // 64-bit word loads: sign vs zero extension
    issue("lw64", 1'b0, 3'b010, 32'h4, 64'h0);
    beat("lw64_b0", 1'b1, 32'h0, 8'hF0, 64'h0, 64'h80000000_00000000, 0);
    resp("lw64", 64'hFFFFFFFF80000000, 1'b0, 1'b0);
    issue("lwu64", 1'b0, 3'b110, 32'h4, 64'h0);
    beat("lwu64_b0", 1'b1, 32'h0, 8'hF0, 64'h0, 64'h80000000_00000000, 0);
    resp("lwu64", 64'h0000000080000000, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
